shift_deserializer: RTL and testbench
=====================================

// Module: shift_deserializer
// PURPOSE
//  Serial-to-parallel receiver paired with the universal shift register used as a
//  transmitter. Samples serIn on bit strobes, MSB first (shift register drives its
//  MSB on serOut and shifts left). Frames each word with a start-of-frame sync and
//  presents complete words on a one-deep valid/ready output buffer.
// PARAMETERS
//  SIZE     8   word width in bits; legal range >= 2
// PORTS
//  clk       in   1           single clock; all state updates on rising edge
//  rst_n     in   1           asynchronous active-low reset
//  en        in   1           bit strobe; serIn is sampled only when en=1
//  sync      in   1           start-of-frame; valid only with en=1, marks the first bit
//  serIn     in   1           serial data, MSB first
//  dataOut   out  SIZE        received word, stable while dataValid=1
//  dataValid out  1           output buffer holds an unconsumed word
//  dataReady in   1           consumer accepts the word when dataValid & dataReady
//  overrun   out  1           1-cycle pulse: completed word dropped, buffer full
//  frameErr  out  1           1-cycle pulse: sync seen mid-frame, partial word discarded
// BEHAVIOUR
//  - Reset, async assert: state=IDLE, bit count=0, shift reg=0, dataOut=0,
//    dataValid=0, overrun=0, frameErr=0.
//  - FSM states: IDLE, SHIFT (+ PARITY when DESER_PARITY_EN is defined).
//  - IDLE: en&sync -> shift serIn in, count=1, go SHIFT. en without sync is ignored.
//  - SHIFT: en&!sync -> sr <= {sr[SIZE-2:0], serIn}, count++.
//    Completion occurs on the en cycle that brings count to SIZE; then go IDLE.
//  - SHIFT, en&sync: frameErr pulses next cycle; partial word is discarded. The
//    current bit starts a new frame: count=1, stay in SHIFT.
//  - Completion with buffer free, or dataValid&dataReady in the same cycle:
//    the word is loaded into dataOut and dataValid=1 the following cycle.
//  - Latency: last-bit en edge -> dataValid high 1 cycle later.
//  - Completion with dataValid=1 & dataReady=0: the new word is dropped, dataOut
//    keeps the old word, and overrun pulses for 1 cycle.
//  - Consume (dataValid&dataReady) with no completion: dataValid=0 next cycle;
//    dataOut holds its last value.
//  - The bit count never exceeds SIZE and never wraps. en=0 cycles are idle gaps of
//    any length, and the frame continues afterwards.
//  - dataReady is ignored when dataValid=0. sync with en=0 is ignored.
//  - Async reset mid-frame: partial word and buffered word are both lost.
//    The first post-reset frame requires sync.
// CONFIGURATION
//  DESER_PARITY_EN defined:
//  - After SIZE bits, go to PARITY; the next en bit is an even-parity bit.
//  - Completion occurs on the parity bit. A sync in PARITY is treated as mid-frame
//    (frameErr).
//  - Extra port: parErr out 1. It is registered with dataOut and is valid while
//    dataValid=1. parErr=1 when ^{word,parityBit}==1. Reset value 0.
//  DESER_PARITY_EN not defined:
//  - No PARITY state and no parErr port; completion occurs on bit SIZE.
// TESTING
//  1. rst_n=0 mid-frame -> all outputs 0 immediately.
//     Then send 0xA5 with sync -> dataOut=0xA5.
//  2. SIZE=8, dataReady=1: send 0x3C as 8 strobes with gaps of 0-3 cycles ->
//     dataValid=1 exactly 1 cycle after the 8th en; dataOut=0x3C.
//  3. dataReady=0: send 0x11, then 0x22 -> overrun pulses once; dataOut stays 0x11.
//     After dataReady=1, one transfer of 0x11, then dataValid=0.
//  4. Send 4 bits of 0xF0, then sync+8 bits of 0x81 -> frameErr pulses once.
//     Then dataOut=0x81.
//  5. Back-to-back 0x01, 0xFE with dataReady=1 on the completion cycle of the second
//     word -> both words delivered in order, no overrun.
//  6. DESER_PARITY_EN: 0x07 + parity 1 -> parErr=0. 0x07 + parity 0 -> parErr=1.

Source files
------------

// File: rtl/shift_deserializer_if.sv
// Interface bundling the serial input, output word buffer and status pulses
// of shift_deserializer. The optional parity-error output exists only when
// DESER_PARITY_EN is defined.
//   master : the deserializer (drives the word buffer and status pulses)
//   slave  : the serial source / word consumer
interface shift_deserializer_if #(
  parameter int SIZE = 8
);
  logic            en;
  logic            sync;
  logic            serIn;
  logic [SIZE-1:0] dataOut;
  logic            dataValid;
  logic            dataReady;
  logic            overrun;
  logic            frameErr;
`ifdef DESER_PARITY_EN
  logic            parErr;

  modport master (
    input  en, sync, serIn, dataReady,
    output dataOut, dataValid, overrun, frameErr, parErr
  );

  modport slave (
    output en, sync, serIn, dataReady,
    input  dataOut, dataValid, overrun, frameErr, parErr
  );
`else
  modport master (
    input  en, sync, serIn, dataReady,
    output dataOut, dataValid, overrun, frameErr
  );

  modport slave (
    output en, sync, serIn, dataReady,
    input  dataOut, dataValid, overrun, frameErr
  );
`endif
endinterface

// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-to-parallel receiver, MSB first.
// A frame starts with sync on a bit strobe; each completed word is offered on a
// one-deep valid/ready buffer. A completed word that finds the buffer full is
// dropped (overrun pulse); a sync inside a frame discards the partial word and
// restarts the frame (frameErr pulse).
// Optional feature macro: DESER_PARITY_EN -- each word is followed by an
// even-parity bit, and parErr is presented alongside dataOut.
module shift_deserializer #(
  parameter int SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_deserializer_if.master bus
);

  localparam int CNT_W = $clog2(SIZE + 1);

`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
  } state_t;
`endif

  // Even-parity check over word and received parity bit: 1 means error.
  function automatic logic even_par_err(input logic [SIZE-1:0] word, input logic par);
    return ^{word, par};
  endfunction

  state_t          state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [SIZE-1:0] sr_r, sr_nx_s;
  logic [SIZE-1:0] word_s;
  logic            complete_s;
  logic            frame_err_nx_s;
  logic            par_err_nx_s;
  logic            load_s;
  logic            overrun_nx_s;

  logic [SIZE-1:0] data_r;
  logic            valid_r;
  logic            overrun_r;
  logic            frame_err_r;
  logic            par_err_r;

  // Frame FSM: next state, bit counter, shift register and completion detect.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    sr_nx_s        = sr_r;
    word_s         = sr_r;
    complete_s     = 1'b0;
    frame_err_nx_s = 1'b0;
    par_err_nx_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.en && bus.sync) begin
          sr_nx_s    = {{(SIZE-1){1'b0}}, bus.serIn};
          cnt_nx_s   = CNT_W'(1);
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        if (bus.en && bus.sync) begin
          // Restart: the current bit becomes bit 1 of a new frame.
          frame_err_nx_s = 1'b1;
          sr_nx_s        = {{(SIZE-1){1'b0}}, bus.serIn};
          cnt_nx_s       = CNT_W'(1);
        end else if (bus.en) begin
          sr_nx_s = {sr_r[SIZE-2:0], bus.serIn};
          if (cnt_r == CNT_W'(SIZE - 1)) begin
`ifdef DESER_PARITY_EN
            cnt_nx_s   = CNT_W'(SIZE);
            state_nx_s = PARITY;
`else
            complete_s = 1'b1;
            word_s     = sr_nx_s;
            cnt_nx_s   = {CNT_W{1'b0}};
            state_nx_s = IDLE;
`endif
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nx_s = SHIFT;
        end
      end
`ifdef DESER_PARITY_EN
      PARITY: begin
        if (bus.en && bus.sync) begin
          frame_err_nx_s = 1'b1;
          sr_nx_s        = {{(SIZE-1){1'b0}}, bus.serIn};
          cnt_nx_s       = CNT_W'(1);
          state_nx_s     = SHIFT;
        end else if (bus.en) begin
          complete_s   = 1'b1;
          word_s       = sr_r;
          par_err_nx_s = even_par_err(sr_r, bus.serIn);
          cnt_nx_s     = {CNT_W{1'b0}};
          state_nx_s   = IDLE;
        end else begin
          state_nx_s = PARITY;
        end
      end
`endif
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Buffer accepts a word when empty or being drained in the same cycle.
  always_comb begin
    load_s       = complete_s && (!valid_r || bus.dataReady);
    overrun_nx_s = complete_s && valid_r && !bus.dataReady;
  end

  // Frame FSM and shift datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      sr_r    <= {SIZE{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      sr_r    <= sr_nx_s;
    end
  end

  // One-deep output buffer and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r      <= {SIZE{1'b0}};
      valid_r     <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      par_err_r   <= 1'b0;
    end else begin
      overrun_r   <= overrun_nx_s;
      frame_err_r <= frame_err_nx_s;
      if (load_s) begin
        data_r    <= word_s;
        par_err_r <= par_err_nx_s;
        valid_r   <= 1'b1;
      end else if (valid_r && bus.dataReady) begin
        valid_r   <= 1'b0;
      end else begin
        valid_r   <= valid_r;
      end
    end
  end

  assign bus.dataOut   = data_r;
  assign bus.dataValid = valid_r;
  assign bus.overrun   = overrun_r;
  assign bus.frameErr  = frame_err_r;
`ifdef DESER_PARITY_EN
  assign bus.parErr    = par_err_r;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed testbench for shift_deserializer (SIZE=8). Inputs change on the
// falling clock edge; registered outputs are checked there as well.
module tb_shift_deserializer;

  localparam int SIZE = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  shift_deserializer_if #(.SIZE(SIZE)) bus ();

  shift_deserializer #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the falling edge, then apply one cycle of inputs.
  task automatic drive(input logic e, input logic s, input logic d);
    @(negedge clk);
    bus.en    = e;
    bus.sync  = s;
    bus.serIn = d;
  endtask

  // Send one word MSB first; gaps of (i%4) idle cycles when gapped=1.
  // With parity enabled, the parity bit par follows the data bits.
  task automatic send_word(input logic [SIZE-1:0] w, input logic with_sync,
                           input logic gapped, input logic par, input logic rdy_last);
    for (int i = SIZE - 1; i >= 0; i--) begin
      drive(1'b1, (i == SIZE - 1) ? with_sync : 1'b0, w[i]);
      if (gapped && i > 0) begin
        for (int g = 0; g < (i % 4); g++) drive(1'b0, 1'b0, 1'b0);
      end
    end
`ifdef DESER_PARITY_EN
    drive(1'b1, 1'b0, par);
`endif
    if (rdy_last) bus.dataReady = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.sync = 1'b0;
    bus.serIn = 1'b0;
    bus.dataReady = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_dataOut", 32'(bus.dataOut), 32'h00);
    check("rst_dataValid", 32'(bus.dataValid), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    check("rst_frameErr", 32'(bus.frameErr), 32'h0);
`ifdef DESER_PARITY_EN
    check("rst_parErr", 32'(bus.parErr), 32'h0);
`endif
    rst_n = 1'b1;

    // Test 1: buffered word plus partial frame, then async reset mid-frame
    send_word(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t1_pre_valid", 32'(bus.dataValid), 32'h1);
    check("t1_pre_data", 32'(bus.dataOut), 32'h5A);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_valid", 32'(bus.dataValid), 32'h0);
    check("t1_rst_data", 32'(bus.dataOut), 32'h00);
    check("t1_rst_overrun", 32'(bus.overrun), 32'h0);
    check("t1_rst_frameErr", 32'(bus.frameErr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // Bits without sync after reset are ignored
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t1_nosync_valid", 32'(bus.dataValid), 32'h0);
    send_word(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t1_valid", 32'(bus.dataValid), 32'h1);
    check("t1_data", 32'(bus.dataOut), 32'hA5);
    bus.dataReady = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("t1_consumed", 32'(bus.dataValid), 32'h0);

    // Test 2: gapped strobes, 1-cycle latency after the last strobe
    send_word(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_valid_before", 32'(bus.dataValid), 32'h0);
    drive(1'b0, 1'b0, 1'b0);
    check("t2_valid", 32'(bus.dataValid), 32'h1);
    check("t2_data", 32'(bus.dataOut), 32'h3C);
    drive(1'b0, 1'b0, 1'b0);
    check("t2_consumed", 32'(bus.dataValid), 32'h0);

    // Test 3: overrun while buffer full
    bus.dataReady = 1'b0;
    send_word(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t3_first_valid", 32'(bus.dataValid), 32'h1);
    check("t3_first_data", 32'(bus.dataOut), 32'h11);
    check("t3_no_overrun", 32'(bus.overrun), 32'h0);
    send_word(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t3_overrun", 32'(bus.overrun), 32'h1);
    check("t3_keep_data", 32'(bus.dataOut), 32'h11);
    check("t3_keep_valid", 32'(bus.dataValid), 32'h1);
    drive(1'b0, 1'b0, 1'b0);
    check("t3_overrun_end", 32'(bus.overrun), 32'h0);
    bus.dataReady = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("t3_drained", 32'(bus.dataValid), 32'h0);
    check("t3_hold_data", 32'(bus.dataOut), 32'h11);

    // Test 4: 4 bits of 0xF0, then sync + 0x81 (with an en=0 sync gap)
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    check("t4_no_ferr", 32'(bus.frameErr), 32'h0);
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, 1'b0, (i == 0) ? 1'b1 : 1'b0);
      if (i == 6) check("t4_ferr", 32'(bus.frameErr), 32'h1);
      if (i == 5) check("t4_ferr_end", 32'(bus.frameErr), 32'h0);
      if (i == 3) begin
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("t4_idle_sync", 32'(bus.frameErr), 32'h0);
      end
    end
`ifdef DESER_PARITY_EN
    drive(1'b1, 1'b0, 1'b0);
`endif
    drive(1'b0, 1'b0, 1'b0);
    check("t4_valid", 32'(bus.dataValid), 32'h1);
    check("t4_data", 32'(bus.dataOut), 32'h81);
    check("t4_overrun", 32'(bus.overrun), 32'h0);
    drive(1'b0, 1'b0, 1'b0);

    // Test 5: 0x01 held, 0xFE completes while the consumer takes 0x01
    bus.dataReady = 1'b0;
    send_word(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t5_first_valid", 32'(bus.dataValid), 32'h1);
    check("t5_first_data", 32'(bus.dataOut), 32'h01);
    send_word(8'hFE, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("t5_second_valid", 32'(bus.dataValid), 32'h1);
    check("t5_second_data", 32'(bus.dataOut), 32'hFE);
    check("t5_no_overrun", 32'(bus.overrun), 32'h0);
    drive(1'b0, 1'b0, 1'b0);
    check("t5_drained", 32'(bus.dataValid), 32'h0);

`ifdef DESER_PARITY_EN
    // Test 6: parity check on 0x07
    send_word(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t6_data_a", 32'(bus.dataOut), 32'h07);
    check("t6_parok", 32'(bus.parErr), 32'h0);
    send_word(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t6_data_b", 32'(bus.dataOut), 32'h07);
    check("t6_parerr", 32'(bus.parErr), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
